// File: rtl/dvi_i2c_write_master.sv
// Hardware-timed 3-byte I2C write engine (device address, register, data) behind a
// 5-port PicoBlaze register window: DEV, REG, DATA, START strobe, STATUS.
module dvi_i2c_write_master #(
    parameter int          QTR_DIV   = 312,
    parameter logic [7:0]  BASE_PORT = 8'h00
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] PORT_ID,
    input  logic [7:0] OUT_PORT,
    input  logic       WRITE_STROBE,
    input  logic       READ_STROBE,
    output logic [7:0] IN_PORT,
    input  logic       SDA_IN,
    output logic       SDA_OE,
    output logic       SCL_OE,
    output logic       BUSY
);

    localparam int         QW     = $clog2(QTR_DIV);
    localparam logic [7:0] P_DEV  = BASE_PORT;
    localparam logic [7:0] P_REG  = BASE_PORT + 8'd1;
    localparam logic [7:0] P_DATA = BASE_PORT + 8'd2;
    localparam logic [7:0] P_GO   = BASE_PORT + 8'd3;
    localparam logic [7:0] P_STAT = BASE_PORT + 8'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_BIT,
        ST_ACK,
        ST_STOP
    } state_t;

    state_t         state, state_n;
    logic [1:0]     qtr, qtr_n;
    logic [2:0]     bitn, bitn_n;
    logic [1:0]     byten, byten_n;
    logic [QW-1:0]  qcnt;
    logic           tick, go, finish, ack_smp, nack, done, cur_bit;
    logic [7:0]     dev_r, reg_r, data_r, tx_dev, tx_reg, tx_data, cur_byte, rd_data;
    logic [1:0]     drv_n;
    logic           unused_rd;

    assign unused_rd = READ_STROBE;
    assign BUSY      = (state != ST_IDLE);
    assign go        = WRITE_STROBE && (PORT_ID == P_GO) && (state == ST_IDLE);
    assign tick      = (state != ST_IDLE) && (qcnt == QW'(QTR_DIV - 1));

    // Line drive per phase as {scl_oe, sda_oe}; 1 pulls the line low.
    function automatic logic [1:0] drive(input state_t s, input logic [1:0] q, input logic b);
        logic [1:0] r;
        r = 2'b00;
        case (s)
            ST_START: r = (q == 2'd0) ? 2'b00 : (q == 2'd1) ? 2'b01 : 2'b11;
            ST_BIT:   r = {~q[1], ~b};
            ST_ACK:   r = {~q[1], 1'b0};
            ST_STOP:  r = (q == 2'd0) ? 2'b11 : (q == 2'd1) ? 2'b01 : 2'b00;
            default:  r = 2'b00;
        endcase
        return r;
    endfunction

    always_comb begin
        state_n = state;
        qtr_n   = qtr;
        bitn_n  = bitn;
        byten_n = byten;
        finish  = 1'b0;
        if (state == ST_IDLE) begin
            if (go) begin
                state_n = ST_START;
                qtr_n   = 2'd0;
            end
        end else if (tick) begin
            qtr_n = qtr + 2'd1;
            if (qtr == 2'd3) begin
                case (state)
                    ST_START: begin
                        state_n = ST_BIT;
                        bitn_n  = 3'd0;
                        byten_n = 2'd0;
                    end
                    ST_BIT: begin
                        if (bitn == 3'd7) state_n = ST_ACK;
                        else              bitn_n  = bitn + 3'd1;
                    end
                    ST_ACK: begin
                        if (ack_smp || byten == 2'd2) begin
                            state_n = ST_STOP;
                        end else begin
                            state_n = ST_BIT;
                            bitn_n  = 3'd0;
                            byten_n = byten + 2'd1;
                        end
                    end
                    ST_STOP: begin
                        state_n = ST_IDLE;
                        finish  = 1'b1;
                    end
                    default: state_n = ST_IDLE;
                endcase
            end
        end
    end

    // Outputs are registered from the next-state decode so they change exactly at the
    // phase boundary without combinational glitches on the bus.
    always_comb begin
        case (byten_n)
            2'd0:    cur_byte = tx_dev;
            2'd1:    cur_byte = tx_reg;
            default: cur_byte = tx_data;
        endcase
        cur_bit = cur_byte[3'd7 - bitn_n];
        drv_n   = drive(state_n, qtr_n, cur_bit);
    end

    always_comb begin
        rd_data = '0;
        if      (PORT_ID == P_DEV)  rd_data = dev_r;
        else if (PORT_ID == P_REG)  rd_data = reg_r;
        else if (PORT_ID == P_DATA) rd_data = data_r;
        else if (PORT_ID == P_STAT) rd_data = {5'b0, done, nack, BUSY};
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= ST_IDLE;
            qtr     <= '0;
            bitn    <= '0;
            byten   <= '0;
            qcnt    <= '0;
            SCL_OE  <= 1'b0;
            SDA_OE  <= 1'b0;
            IN_PORT <= '0;
            dev_r   <= '0;
            reg_r   <= '0;
            data_r  <= '0;
            tx_dev  <= '0;
            tx_reg  <= '0;
            tx_data <= '0;
            ack_smp <= 1'b0;
            nack    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            qtr     <= qtr_n;
            bitn    <= bitn_n;
            byten   <= byten_n;
            qcnt    <= (state == ST_IDLE || tick) ? '0 : qcnt + QW'(1);
            {SCL_OE, SDA_OE} <= drv_n;
            IN_PORT <= rd_data;
            if (WRITE_STROBE && PORT_ID == P_DEV)  dev_r  <= OUT_PORT;
            if (WRITE_STROBE && PORT_ID == P_REG)  reg_r  <= OUT_PORT;
            if (WRITE_STROBE && PORT_ID == P_DATA) data_r <= OUT_PORT;
            if (go) begin
                tx_dev  <= {dev_r[7:1], 1'b0};
                tx_reg  <= reg_r;
                tx_data <= data_r;
                nack    <= 1'b0;
                done    <= 1'b0;
            end
            if (state == ST_ACK && tick && qtr == 2'd2) begin
                ack_smp <= SDA_IN;
                if (SDA_IN) nack <= 1'b1;
            end
            if (finish) done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dvi_i2c_write_master.sv
// Directed and randomised checks of the I2C write engine against a per-quarter
// bus waveform model built from the protocol rules.
module tb_dvi_i2c_write_master;

    localparam int         Q    = 4;
    localparam logic [7:0] BASE = 8'h00;

    logic       clk = 1'b0;
    logic       RESET, WRITE_STROBE, READ_STROBE, SDA_IN;
    logic [7:0] PORT_ID, OUT_PORT, IN_PORT;
    logic       SDA_OE, SCL_OE, BUSY;

    int n_cmp = 0;
    int n_err = 0;

    always #4 clk = ~clk;

    dvi_i2c_write_master #(.QTR_DIV(Q), .BASE_PORT(BASE)) dut (
        .CLK(clk), .RESET(RESET), .PORT_ID(PORT_ID), .OUT_PORT(OUT_PORT),
        .WRITE_STROBE(WRITE_STROBE), .READ_STROBE(READ_STROBE), .IN_PORT(IN_PORT),
        .SDA_IN(SDA_IN), .SDA_OE(SDA_OE), .SCL_OE(SCL_OE), .BUSY(BUSY)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [7:0] off, input logic [7:0] val);
        @(negedge clk);
        PORT_ID = BASE + off;
        OUT_PORT = val;
        WRITE_STROBE = 1'b1;
        @(negedge clk);
        WRITE_STROBE = 1'b0;
    endtask

    task automatic rd_port(input string tag, input logic [7:0] port, input logic [7:0] exp);
        @(negedge clk);
        PORT_ID = port;
        READ_STROBE = 1'b1;
        @(negedge clk);
        READ_STROBE = 1'b0;
        chk(tag, IN_PORT, exp);
    endtask

    task automatic load(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
        wr(8'd0, d0);
        wr(8'd1, d1);
        wr(8'd2, d2);
    endtask

    // nack_byte: index of the byte whose ACK slot the slave leaves high (3 = all ACKed).
    // inj_start/inj_data: cycle numbers for a mid-transfer START/DATA write (0 = none).
    // abort_q: quarter during which RESET is asserted (-1 = none).
    task automatic run_txn(input string tag, input logic [7:0] d0, input logic [7:0] d1,
                           input logic [7:0] d2, input int nack_byte, input int inj_start,
                           input int inj_data, input int abort_q);
        logic [1:0] exp_q[$];
        logic       sdain_q[$];
        logic [7:0] b [3];
        int         total, busy_n, k, ph;
        b[0] = {d0[7:1], 1'b0};
        b[1] = d1;
        b[2] = d2;
        exp_q = '{2'b00, 2'b01, 2'b11, 2'b11};
        sdain_q = '{1'b1, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 3; i++) begin
            for (int j = 7; j >= 0; j--)
                for (int p = 0; p < 4; p++) begin
                    exp_q.push_back({(p < 2), ~b[i][j]});
                    sdain_q.push_back(1'b1);
                end
            for (int p = 0; p < 4; p++) begin
                exp_q.push_back({(p < 2), 1'b0});
                sdain_q.push_back(i == nack_byte);
            end
            if (i == nack_byte) break;
        end
        exp_q.push_back(2'b11); exp_q.push_back(2'b01);
        exp_q.push_back(2'b00); exp_q.push_back(2'b00);
        repeat (4) sdain_q.push_back(1'b1);
        total = exp_q.size() * Q;
        busy_n = 0;

        wr(8'd3, 8'($urandom));
        for (int n = 1; n <= total + 40; n++) begin
            if (n > 1) @(negedge clk);
            k = (n - 1) / Q;
            ph = (n - 1) % Q;
            if (abort_q >= 0 && k == abort_q && ph == 1) begin
                RESET = 1'b1;
                @(negedge clk);
                RESET = 1'b0;
                chk({tag, " rst sda_oe"}, SDA_OE, 1'b0);
                chk({tag, " rst scl_oe"}, SCL_OE, 1'b0);
                chk({tag, " rst busy"}, BUSY, 1'b0);
                return;
            end
            if (ph == 1 && k < exp_q.size()) begin
                chk($sformatf("%s q%0d scl_oe", tag, k), SCL_OE, exp_q[k][1]);
                chk($sformatf("%s q%0d sda_oe", tag, k), SDA_OE, exp_q[k][0]);
            end
            WRITE_STROBE = 1'b0;
            if (n == 2) PORT_ID = BASE + 8'd4;
            if (n == 3) chk({tag, " status in flight"}, IN_PORT, 8'h01);
            if (n == inj_start) begin
                PORT_ID = BASE + 8'd3;
                OUT_PORT = 8'h00;
                WRITE_STROBE = 1'b1;
            end
            if (n == inj_data) begin
                PORT_ID = BASE + 8'd2;
                OUT_PORT = 8'h5A;
                WRITE_STROBE = 1'b1;
            end
            SDA_IN = (k < sdain_q.size()) ? sdain_q[k] : 1'b1;
            if (BUSY) busy_n++;
            else break;
        end
        SDA_IN = 1'b1;
        chk({tag, " busy cycles"}, busy_n, total);
        rd_port({tag, " status end"}, BASE + 8'd4, (nack_byte < 3) ? 8'h06 : 8'h04);
    endtask

    initial begin
        logic [7:0] r0, r1, r2;
        int         nb;
        RESET = 1'b1;
        WRITE_STROBE = 1'b0;
        READ_STROBE = 1'b0;
        PORT_ID = 8'h00;
        OUT_PORT = 8'h00;
        SDA_IN = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset sda_oe", SDA_OE, 1'b0);
        chk("reset scl_oe", SCL_OE, 1'b0);
        chk("reset busy", BUSY, 1'b0);
        chk("reset in_port", IN_PORT, 8'h00);
        RESET = 1'b0;
        rd_port("reset status", BASE + 8'd4, 8'h00);
        rd_port("reset dev", BASE + 8'd0, 8'h00);

        wr(8'd1, 8'h21);
        rd_port("read reg", BASE + 8'd1, 8'h21);
        rd_port("read unmapped 7f", 8'h7F, 8'h00);
        rd_port("read unmapped 05", BASE + 8'd5, 8'h00);

        load(8'hEC, 8'h49, 8'hC0);
        rd_port("read dev", BASE + 8'd0, 8'hEC);
        run_txn("s1 ack all", 8'hEC, 8'h49, 8'hC0, 3, 0, 0, -1);
        run_txn("s2 nack dev", 8'hEC, 8'h49, 8'hC0, 0, 0, 0, -1);
        run_txn("s6 after nack", 8'hEC, 8'h49, 8'hC0, 3, 0, 0, -1);
        run_txn("s3 restart ignored", 8'hEC, 8'h49, 8'hC0, 3, 10, 200, -1);
        rd_port("s3 data reg updated", BASE + 8'd2, 8'h5A);

        wr(8'd2, 8'hC0);
        run_txn("s4 abort", 8'hEC, 8'h49, 8'hC0, 3, 0, 0, 4 + 36 + 8);
        rd_port("s4 status", BASE + 8'd4, 8'h00);
        rd_port("s4 dev cleared", BASE + 8'd0, 8'h00);
        load(8'hEC, 8'h49, 8'hC0);
        run_txn("s4 rerun", 8'hEC, 8'h49, 8'hC0, 3, 0, 0, -1);

        repeat (5) begin
            r0 = 8'($urandom);
            r1 = 8'($urandom);
            r2 = 8'($urandom);
            nb = int'($urandom_range(0, 3));
            load(r0, r1, r2);
            run_txn($sformatf("rnd %h %h %h nb%0d", r0, r1, r2, nb), r0, r1, r2, nb, 0, 0, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dvi_i2c_write_master.md
Name: dvi_i2c_write_master

Overview:
Byte-level I2C write engine mapped onto the PicoBlaze (KCPSM3) port bus. It sits directly downstream of the DVI init program ROM and its processor, and replaces bit-banged SDA/SCL with hardware-timed 3-byte writes to the DVI transmitter: device address, register address, data. Firmware loads three registers, writes a start strobe, then polls status.

Parameters:
QTR_DIV, 312, CLK cycles per SCL quarter-period (125 MHz / (4*312) ≈ 100 kHz); minimum 2.
BASE_PORT, 8'h00, first port ID of the 5-port register window.

Ports:
CLK  in  1  system clock, 125 MHz.
RESET  in  1  synchronous, active-high reset.
PORT_ID  in  8  PicoBlaze port address.
OUT_PORT  in  8  PicoBlaze write data.
WRITE_STROBE  in  1  one-cycle write qualifier.
READ_STROBE  in  1  one-cycle read qualifier; unused internally, present for bus symmetry.
IN_PORT  out  8  registered read data.
SDA_IN  in  1  sampled SDA line, already synchronised externally.
SDA_OE  out  1  1 = pull SDA low; 0 = release.
SCL_OE  out  1  1 = pull SCL low; 0 = release.
BUSY  out  1  transaction in progress.

Behaviour:
- Single clock CLK; RESET is synchronous and active-high.
- Register map, relative to BASE_PORT:
  - +0 DEV: 7-bit address in [7:1]; bit0 is forced to 0 on the wire.
  - +1 REG.
  - +2 DATA.
  - +3 write of any value = START.
  - +4 STATUS, read only: bit0 BUSY, bit1 NACK, bit2 DONE, others 0.
- Writes to +0..+2 are accepted at any time. A transaction uses copies latched when START is accepted. START while BUSY=1 is ignored and sets no flags.
- IN_PORT is registered: the cycle after PORT_ID=+n, it shows that register's content. Unmapped IDs read 8'h00.
- Reset values: SDA_OE=0, SCL_OE=0, BUSY=0, IN_PORT=0, NACK=0, DONE=0, DEV/REG/DATA=0, FSM=IDLE, quarter counter=0.
- Quarter tick: counter runs 0..QTR_DIV-1 only while not IDLE. Tick on the terminal count. Every state phase lasts exactly one quarter.
- FSM states: IDLE, START, BIT, ACK, STOP.
  - IDLE: both OE=0. On START, latch copies, clear NACK and DONE, set BUSY next cycle, go to START.
  - START (4 quarters), as (SCL,SDA) released/low:
    - q0: SCL high, SDA high.
    - q1: SCL high, SDA low.
    - q2, q3: SCL low, SDA low.
  - BIT: 8 bits per byte, MSB first, 4 quarters per bit.
    - q0: SCL low, SDA set to the bit.
    - q1: SCL low.
    - q2, q3: SCL high.
  - ACK: same 4-quarter shape with SDA released. SDA_IN is sampled on the last CLK of q2.
    - Sample 0: next byte, or STOP after byte 3.
    - Sample 1: set NACK and go to STOP immediately, skipping remaining bytes.
  - Byte order: DEV, REG, DATA.
  - STOP (4 quarters):
    - q0: SCL low, SDA low.
    - q1: SCL high, SDA low.
    - q2, q3: SCL high, SDA high (bus-free time).
    - Then set DONE, clear BUSY, return to IDLE.
- Total duration of a successful transaction: 4 + 3*36 + 4 = 116 quarters = 116*QTR_DIV CLK cycles from START acceptance to BUSY falling.
- DONE is set on both success and NACK. NACK and DONE are sticky until the next accepted START or RESET.
- No clock stretching support; SCL is driven open-drain and never sampled.
- RESET mid-transaction: outputs return to reset values on the next edge. The bus is released without a STOP; firmware re-issues the transaction.
- Simultaneous config write and START in one cycle is impossible, since a single port write occurs per cycle.

Test Plan:
1. QTR_DIV=4, load DEV=8'hEC, REG=8'h49, DATA=8'hC0, START, slave ACKs all -> SDA bit stream 1110_1100/0 0100_1001/0 1100_0000/0; BUSY high exactly 464 cycles; STATUS reads 8'h04.
2. Same load, SDA_IN=1 at first ACK -> STOP follows directly after ACK1, BUSY high 4+36+4=44 quarters (176 cycles), STATUS=8'h06.
3. START written again 10 cycles after the first -> ignored; waveform and duration identical to scenario 1; latched copies unaffected by a DATA write mid-transfer.
4. RESET asserted during bit 5 of REG byte -> next cycle SDA_OE=0, SCL_OE=0, BUSY=0, STATUS=8'h00; a following START runs a full, correct transaction.
5. Read PORT_ID=BASE_PORT+1 after writing 8'h21 -> IN_PORT=8'h21 one cycle later; PORT_ID=8'h7F -> IN_PORT=8'h00.
6. Second START after NACK -> NACK and DONE cleared at acceptance; successful completion gives STATUS=8'h04.
